// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down counter of toggle-mode JK stages; define JK_COUNTER_TC_REG_EN for a registered TC
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q,
  output logic             TC
);
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, cnt, toggle, jk_next;
  logic             oor;
  // arithmetic next state, then JK excitation (J=K=toggle) per stage derived from it
  always_comb begin
    oor     = {1'b0, q_q} >= MOD;
    cnt     = oor ? '0 : UP ? ((q_q == MAX) ? '0 : q_q + 1'b1) : ((q_q == '0) ? MAX : q_q - 1'b1);
    q_d     = LOAD ? (({1'b0, D} < MOD) ? D : MAX) : EN ? cnt : q_q;
    toggle  = q_d ^ q_q;
    jk_next = (toggle & ~q_q) | (~toggle & q_q);
  end
  // JK stage flops: each bit takes the JK toggle/hold result
  always_ff @(posedge CLK or negedge not_RST) begin
    if (!not_RST) q_q <= '0;
    else q_q <= jk_next;
  end
  assign Q     = q_q;
  assign not_Q = ~q_q;
`ifdef JK_COUNTER_TC_REG_EN
  logic tc_q, tc_d;
  // registered TC looks at the value Q takes at this edge
  always_comb begin
    tc_d = UP ? (q_d == MAX) : (q_d == '0);
  end
  // TC flop, cleared by reset
  always_ff @(posedge CLK or negedge not_RST) begin
    if (!not_RST) tc_q <= 1'b0;
    else tc_q <= tc_d;
  end
  assign TC = tc_q;
`else
  assign TC = EN & ~LOAD & (UP ? (q_q == MAX) : (q_q == '0));
`endif
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: vector table + scoreboard bench for jk_sync_counter (WIDTH=4, MODULUS=10)
module tb_jk_sync_counter;
  logic       CLK = 1'b0;
  logic       not_RST, EN, UP, LOAD;
  logic [3:0] D, Q, not_Q;
  logic       TC;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .not_RST(not_RST), .EN(EN), .UP(UP), .LOAD(LOAD),
    .D(D), .Q(Q), .not_Q(not_Q), .TC(TC)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic load, input logic en, input logic up, input logic [3:0] d,
                     input logic [3:0] q, input logic tc);
    vec_t v;
    v.load = load; v.en = en; v.up = up; v.d = d; v.exp_q = q; v.exp_tc = tc;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge CLK);
    LOAD = v.load; EN = v.en; UP = v.up; D = v.d;
    #2;
`ifndef JK_COUNTER_TC_REG_EN
    check("tc_comb", {3'b0, TC}, {3'b0, v.exp_tc});
`endif
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check("q", Q, e.exp_q);
      check("not_q", not_Q, ~e.exp_q);
`ifdef JK_COUNTER_TC_REG_EN
      check("tc_reg", {3'b0, TC}, {3'b0, e.up ? (e.exp_q == 4'd9) : (e.exp_q == 4'd0)});
`endif
    end
  endtask

  initial begin
    for (int i = 1; i <= 12; i++)
      add(0, 1, 1, 0, 4'((i) % 10), (i == 10));
    add(1, 0, 0, 2, 2, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 9, 1);
    add(0, 1, 0, 0, 8, 0);
    add(1, 1, 1, 5, 5, 0);
    add(1, 1, 1, 13, 9, 0);
    add(1, 0, 1, 4, 4, 0);
    add(0, 0, 1, 0, 4, 0);
    add(0, 0, 0, 0, 4, 0);
    add(0, 0, 1, 0, 4, 0);
    add(0, 1, 1, 0, 5, 0);
    add(0, 1, 0, 0, 4, 0);
    add(0, 1, 1, 0, 5, 0);
    add(1, 0, 1, 10, 9, 0);
    add(1, 0, 1, 9, 9, 0);
    add(0, 1, 1, 0, 0, 1);
    add(1, 1, 0, 15, 9, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 9, 1);
    add(1, 0, 1, 8, 8, 0);
    add(0, 1, 1, 0, 9, 0);
    add(0, 0, 1, 0, 9, 0);
    add(1, 0, 1, 7, 7, 0);

    not_RST = 1'b0; EN = 1'b0; UP = 1'b0; LOAD = 1'b0; D = 4'd0;
    #3;
    check("rst_q", Q, 4'h0);
    check("rst_not_q", not_Q, 4'hF);
    check("rst_tc", {3'b0, TC}, 4'h0);
    @(negedge CLK);
    not_RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    @(negedge CLK);
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    #2;
    not_RST = 1'b0;
    #1;
    check("async_rst_q", Q, 4'h0);
    check("async_rst_not_q", not_Q, 4'hF);
    check("async_rst_tc", {3'b0, TC}, 4'h0);
    @(posedge CLK);
    #1;
    check("rst_hold_q", Q, 4'h0);
    check("rst_hold_tc", {3'b0, TC}, 4'h0);
    @(negedge CLK);
    not_RST = 1'b1;
    EN = 1'b0;
    begin
      vec_t v;
      v.load = 0; v.en = 1; v.up = 1; v.d = 0; v.exp_q = 1; v.exp_tc = 0;
      apply(v);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
